// File: rtl/hdmi_timing_gen_pkg.sv
// Shared video timing constants and types for the HDMI output path.
// The default 640x480@60 timing lives here so the display driver and the
// timing generator agree on the same numbers.
package hdmi_timing_gen_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int CNT_W = 10;

  // One stage worth of timing strobes (syncs active-low).
  typedef struct packed {
    logic de;
    logic hsync_n;
    logic vsync_n;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{de: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1};

endpackage

// File: rtl/hdmi_sync_counter.sv
// One axis of the timing generator (horizontal or vertical).
// Ports:
//   clk_hdmi, rst   : pixel clock, async active-high reset
//   en              : advance the count this cycle
//   term            : last count value before wrapping to 0
//   sync_start/end  : sync pulse window [start, end)
//   active_end      : active region is count < active_end
//   count           : current count
//   active, sync_n  : region decode of the current count (sync active-low)
//   wrap            : high in the cycle the count steps from term to 0
module hdmi_sync_counter #(
  parameter int W = 10
) (
  input  logic         clk_hdmi,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] term,
  input  logic [W-1:0] sync_start,
  input  logic [W-1:0] sync_end,
  input  logic [W-1:0] active_end,
  output logic [W-1:0] count,
  output logic         active,
  output logic         sync_n,
  output logic         wrap
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    // Beyond term is unreachable in normal operation; recover to 0.
    if (count_q > term)      count_d = '0;
    else if (en)             count_d = (count_q == term) ? '0 : count_q + W'(1);
  end

  always_ff @(posedge clk_hdmi or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count  = count_q;
  assign wrap   = en && (count_q == term);
  assign active = count_q < active_end;
  assign sync_n = ~((count_q >= sync_start) && (count_q < sync_end));

endmodule

// File: rtl/hdmi_timing_gen.sv
// Free-running video timing generator plus transmitter output stage.
// Ports:
//   clk_hdmi, rst          : pixel clock, async active-high reset
//   HDMI_DE/HSYNC/VSYNC    : stage-1 strobes to the display driver
//   HDMI_DO                : pixel returned by the driver while HDMI_DE is high
//   tx_de/hsync/vsync/data : stage-2 outputs to the HDMI transmitter chip
//   frame_start            : pulse with the first active pixel of a frame
//   h_count, v_count       : raw counters (one cycle ahead of HDMI_*)
module hdmi_timing_gen
  import hdmi_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic             clk_hdmi,
  input  logic             rst,
  output logic             HDMI_DE,
  output logic             HDMI_HSYNC,
  output logic             HDMI_VSYNC,
  input  logic [23:0]      HDMI_DO,
  output logic             tx_de,
  output logic             tx_hsync,
  output logic             tx_vsync,
  output logic [23:0]      tx_data,
  output logic             frame_start,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_TERM  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SS    = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_AE    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_TERM  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_SS    = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_AE    = CNT_W'(V_ACTIVE);

  logic             h_active, h_sync_n, h_wrap;
  logic             v_active, v_sync_n, v_wrap_unused;
  logic [CNT_W-1:0] h_cnt, v_cnt;

  hdmi_sync_counter #(.W(CNT_W)) u_h (
    .clk_hdmi   (clk_hdmi),
    .rst        (rst),
    .en         (1'b1),
    .term       (H_TERM),
    .sync_start (H_SS),
    .sync_end   (H_SE),
    .active_end (H_AE),
    .count      (h_cnt),
    .active     (h_active),
    .sync_n     (h_sync_n),
    .wrap       (h_wrap)
  );

  // Vertical axis steps once per line, so vsync edges land on h=0.
  hdmi_sync_counter #(.W(CNT_W)) u_v (
    .clk_hdmi   (clk_hdmi),
    .rst        (rst),
    .en         (h_wrap),
    .term       (V_TERM),
    .sync_start (V_SS),
    .sync_end   (V_SE),
    .active_end (V_AE),
    .count      (v_cnt),
    .active     (v_active),
    .sync_n     (v_sync_n),
    .wrap       (v_wrap_unused)
  );

  sync_t       s1_q, s1_d, s2_q, s2_d;
  logic        fs_q, fs_d;
  logic [23:0] txd_q, txd_d;

  always_comb begin
    s1_d.de      = h_active && v_active;
    s1_d.hsync_n = h_sync_n;
    s1_d.vsync_n = v_sync_n;
    fs_d         = (h_cnt == '0) && (v_cnt == '0);
    s2_d         = s1_q;
    // Pixel is qualified by the stage-1 DE it was produced against, so
    // tx_data and tx_de stay aligned and blanking data is squashed.
    txd_d        = s1_q.de ? HDMI_DO : 24'h0;
  end

  always_ff @(posedge clk_hdmi or posedge rst) begin
    if (rst) begin
      s1_q  <= SYNC_IDLE;
      s2_q  <= SYNC_IDLE;
      fs_q  <= 1'b0;
      txd_q <= 24'h0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      fs_q  <= fs_d;
      txd_q <= txd_d;
    end
  end

  assign HDMI_DE     = s1_q.de;
  assign HDMI_HSYNC  = s1_q.hsync_n;
  assign HDMI_VSYNC  = s1_q.vsync_n;
  assign tx_de       = s2_q.de;
  assign tx_hsync    = s2_q.hsync_n;
  assign tx_vsync    = s2_q.vsync_n;
  assign tx_data     = txd_q;
  assign frame_start = fs_q;
  assign h_count     = h_cnt;
  assign v_count     = v_cnt;

endmodule
